idx_sort_core: RTL
==================

Name: idx_sort_core

Overview:
Parametrised successor to the two-index/comparator sort datapath, with the FSM, index registers, storage and comparator merged into one self-contained block. It holds up to DEPTH words of WIDTH bits, loaded serially, and sorts them in place with an i/j exchange sort (one compare-and-swap per clock). It sorts ascending or descending, then exposes the result on a combinational read port. It sits between the operand-load logic and the result readout of the SSC datapath.

Parameters:
WIDTH, 16, data word width in bits (>=1)
DEPTH, 16, storage entries (>=2)
IDX_W, $clog2(DEPTH), index width; derived, never overridden

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-high reset
clr  in  1  sync clear: count<=0, FSM to IDLE
wr_en  in  1  write wr_data at entry count
wr_data  in  WIDTH  load data
start  in  1  begin sort of entries 0..count-1
descend  in  1  0 ascending, 1 descending; sampled with start
rd_addr  in  IDX_W  read index
rd_data  out  WIDTH  mem[rd_addr], combinational
count  out  IDX_W+1  number of loaded entries
busy  out  1  high while in SORT
done  out  1  one-cycle pulse on entry to DONE

Behaviour:
- Reset (async, any state, including mid-sort): state IDLE, all mem entries 0, count 0, i 0, j 0, busy 0, done 0, latched mode ascending.
- States: IDLE, SORT, DONE. busy = (state==SORT). done is registered and high only for the first cycle in DONE.
- Priority each cycle: clr > start > wr_en.
- clr in any state: count<=0, state<=IDLE, busy drops next cycle, no done pulse; mem contents retained.
- wr_en in IDLE/DONE with count<DEPTH: mem[count]<=wr_data, count<=count+1. With count==DEPTH: write dropped, count saturates. wr_en in SORT is ignored.
- start in IDLE/DONE: latch descend.
  - count>=2: i<=0, j<=1, state<=SORT.
  - count<2: state<=DONE directly; done pulses next cycle.
  - A wr_en in the same cycle is dropped. start in SORT is ignored.
- SORT, every cycle: compare mem[i] with mem[j], unsigned.
  - Ascending: swap when mem[i] > mem[j].
  - Descending: swap when mem[i] < mem[j].
  - Equal values never swap (stable for duplicates).
  - Swap writes both entries at the clock edge.
- Index update in SORT:
  - If j<count-1: j<=j+1.
  - Else if i<count-2: i<=i+1, j<=i+2.
  - Else: state<=DONE.
- Latency: exactly count*(count-1)/2 SORT cycles; done is high on the following cycle. Example: count 5 gives 10 SORT cycles.
- DONE persists until start, clr or reset. Re-start without clr re-sorts the current contents. Further writes append after count.
- rd_data is valid in any state. During SORT it shows in-progress contents. Entries >= count return the last-written or reset value.

Optional Feature:
SORT_STATS_EN: when defined, adds output port swap_cnt [15:0].
- Cleared on reset, clr and accepted start.
- Increments on each SORT cycle that swaps; saturates at 16'hFFFF.
- Held stable in DONE.
When undefined: no port and no counter logic.

Decomposition:
- Package sort_pkg: state enum typedef sort_state_t {IDLE, SORT, DONE}; localparam defaults SORT_WIDTH=16, SORT_DEPTH=16.
- Sub-module sort_cmp_swap (parameter WIDTH): inputs a, b, descend; output swap.
  - swap = descend ? (a<b) : (a>b).
  - This generalises the fixed 16-bit greater-than comparator.

Test Plan:
- Write 7,3,9,1,5, start, descend=0 -> busy for exactly 10 cycles, done pulse 1 cycle; rd 0..4 = 1,3,5,7,9.
- Same data, descend=1 -> rd 0..4 = 9,7,5,3,1; with SORT_STATS_EN, swap_cnt reflects the swaps performed.
- Write 4,4,2,4; ascending -> 2,4,4,4; all-equal 6,6,6 -> no swaps (swap_cnt=0), 3 SORT cycles.
- count=1 and count=0, start -> no busy, done pulse on next cycle, data unchanged; 17 writes into DEPTH=16 -> count=16, 17th value absent.
- start during SORT and wr_en during SORT -> no effect, sort completes normally; start+wr_en together in IDLE -> write dropped.
- clr at sort cycle 4 -> IDLE next cycle, count=0, no done; rst asserted mid-SORT -> immediately IDLE, all mem 0, count 0, busy 0.

Source files
------------

// File: rtl/sort_pkg.sv
// Shared types and default sizes for the index-exchange sort core.
package sort_pkg;

  localparam int unsigned SORT_WIDTH = 16;
  localparam int unsigned SORT_DEPTH = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SORT = 2'd1,
    DONE = 2'd2
  } sort_state_t;

endpackage

// File: rtl/sort_cmp_swap.sv
// Unsigned compare-and-swap decision for one i/j pair; direction-selectable.
module sort_cmp_swap
  import sort_pkg::*;
#(
  parameter int unsigned WIDTH = SORT_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             descend,
  output logic             swap
);

  // Strict comparisons so equal values never move.
  assign swap = descend ? (a < b) : (a > b);

endmodule

// File: rtl/idx_sort_core.sv
// Serially loaded storage sorted in place by an i/j exchange sort, one compare-and-swap per clock.
// Define SORT_STATS_EN to add the saturating swap_cnt output.
module idx_sort_core
  import sort_pkg::*;
#(
  parameter int unsigned  WIDTH = SORT_WIDTH,
  parameter int unsigned  DEPTH = SORT_DEPTH,
  localparam int unsigned IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             start,
  input  logic             descend,
  input  logic [IDX_W-1:0] rd_addr,
  output logic [WIDTH-1:0] rd_data,
  output logic [IDX_W:0]   count,
`ifdef SORT_STATS_EN
  output logic [15:0]      swap_cnt,
`endif
  output logic             busy,
  output logic             done
);

  localparam int unsigned CNT_W = IDX_W + 1;

  sort_state_t      state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [IDX_W-1:0] i_q, i_d;
  logic [IDX_W-1:0] j_q, j_d;
  logic             desc_q, desc_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             swap;
`ifdef SORT_STATS_EN
  logic [15:0]      swap_cnt_q, swap_cnt_d;
`endif

  sort_cmp_swap #(
    .WIDTH (WIDTH)
  ) u_cmp (
    .a       (mem_q[i_q]),
    .b       (mem_q[j_q]),
    .descend (desc_q),
    .swap    (swap)
  );

  // Next-state: clr beats everything, SORT owns the cycle, then start, then load.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    i_d     = i_q;
    j_d     = j_q;
    desc_d  = desc_q;
    done_d  = 1'b0;
    mem_d   = mem_q;
`ifdef SORT_STATS_EN
    swap_cnt_d = swap_cnt_q;
`endif

    if (clr) begin
      count_d = '0;
      state_d = IDLE;
`ifdef SORT_STATS_EN
      swap_cnt_d = '0;
`endif
    end else if (state_q == SORT) begin
      if (swap) begin
        mem_d[i_q] = mem_q[j_q];
        mem_d[j_q] = mem_q[i_q];
`ifdef SORT_STATS_EN
        if (swap_cnt_q != 16'hFFFF) begin
          swap_cnt_d = swap_cnt_q + 16'd1;
        end
`endif
      end
      // count is frozen in SORT and is at least 2, so the subtractions cannot wrap.
      if (CNT_W'(j_q) < (count_q - CNT_W'(1))) begin
        j_d = j_q + IDX_W'(1);
      end else if (CNT_W'(i_q) < (count_q - CNT_W'(2))) begin
        i_d = i_q + IDX_W'(1);
        j_d = i_q + IDX_W'(2);
      end else begin
        state_d = DONE;
        done_d  = 1'b1;
      end
    end else if (start) begin
      desc_d = descend;
`ifdef SORT_STATS_EN
      swap_cnt_d = '0;
`endif
      if (count_q >= CNT_W'(2)) begin
        i_d     = '0;
        j_d     = IDX_W'(1);
        state_d = SORT;
      end else begin
        state_d = DONE;
        done_d  = 1'b1;
      end
    end else if (wr_en && (count_q < CNT_W'(DEPTH))) begin
      mem_d[count_q[IDX_W-1:0]] = wr_data;
      count_d                   = count_q + CNT_W'(1);
    end

    busy_d = (state_d == SORT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      count_q <= '0;
      i_q     <= '0;
      j_q     <= '0;
      desc_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      mem_q   <= '{default: '0};
`ifdef SORT_STATS_EN
      swap_cnt_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      i_q     <= i_d;
      j_q     <= j_d;
      desc_q  <= desc_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      mem_q   <= mem_d;
`ifdef SORT_STATS_EN
      swap_cnt_q <= swap_cnt_d;
`endif
    end
  end

  assign rd_data = mem_q[rd_addr];
  assign count   = count_q;
  assign busy    = busy_q;
  assign done    = done_q;
`ifdef SORT_STATS_EN
  assign swap_cnt = swap_cnt_q;
`endif

endmodule
